hazard_forward_unit: RTL and testbench

Parametrised hazard and forwarding unit for the pipelined OTTER core, sitting beside the decode stage. It keeps its own shadow pipeline of in-flight destination registers. For every source register of the instruction in decode it resolves:
- a per-source forwarding select, choosing the youngest matching older stage;
- a load-use stall, when load data is not yet forwardable.

---
 rtl/hazard_pkg.sv | 15 +
 rtl/hazard_match.sv | 36 +++
 rtl/hazard_forward_unit.sv | 95 +++++++++
 tb/tb_hazard_forward_unit.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the OTTER hazard/forwarding unit.
package hazard_pkg;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       we;
    logic       load;
  } trk_entry_t;

  localparam logic [4:0]  REG_ZERO      = 5'd0;
  localparam int unsigned SEL_RF        = 0;
  localparam int unsigned SEL_STAGE_OFS = 1;

endpackage

// File: rtl/hazard_match.sv
// Per-source priority matcher: finds the youngest in-flight writer of one source register.
module hazard_match
  import hazard_pkg::*;
#(
  parameter int unsigned FWD_STAGES = 2,
  parameter int unsigned SEL_W      = 2
) (
  input  trk_entry_t [FWD_STAGES-1:0] entries_i,
  input  logic                        id_valid_i,
  input  logic [4:0]                  rs_i,
  input  logic                        rs_used_i,
  output logic                        hit_o,
  output logic [SEL_W-1:0]            sel_o,
  output logic                        is_load_o,
  output logic [SEL_W-1:0]            index_o
);

  always_comb begin
    hit_o     = 1'b0;
    sel_o     = SEL_W'(SEL_RF);
    is_load_o = 1'b0;
    index_o   = '0;
    if (id_valid_i && rs_used_i && (rs_i != REG_ZERO)) begin
      // Walk oldest to youngest so a younger match overwrites an older one.
      for (int k = int'(FWD_STAGES) - 1; k >= 0; k--) begin
        if (entries_i[k].valid && entries_i[k].we && (entries_i[k].rd == rs_i)) begin
          hit_o     = 1'b1;
          sel_o     = SEL_W'(k + int'(SEL_STAGE_OFS));
          is_load_o = entries_i[k].load;
          index_o   = SEL_W'(k);
        end
      end
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard and forwarding unit: shadow tracker of in-flight destinations, per-source
// forwarding selects, load-use stall and a saturating stall counter.
module hazard_forward_unit
  import hazard_pkg::*;
#(
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned FWD_STAGES = 2,
  parameter int unsigned LOAD_LAT   = 1,
  parameter int unsigned SEL_W      = $clog2(FWD_STAGES + 1)
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic                            ID_VALID,
  input  logic [NUM_SRC-1:0][4:0]         ID_RS,
  input  logic [NUM_SRC-1:0]              ID_RS_USED,
  input  logic [4:0]                      ID_RD,
  input  logic                            ID_RF_WE,
  input  logic                            ID_IS_LOAD,
  input  logic                            FLUSH,
  output logic [NUM_SRC-1:0][SEL_W-1:0]   FWD_SEL,
  output logic                            STALL,
  output logic [15:0]                     STALL_CNT
);

  trk_entry_t [FWD_STAGES-1:0] trk_q, trk_d;
  logic [NUM_SRC-1:0]            hit;
  logic [NUM_SRC-1:0]            is_load;
  logic [NUM_SRC-1:0][SEL_W-1:0] idx;
  logic                          stall;
  logic [15:0]                   stall_cnt_q, stall_cnt_d;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_match
    hazard_match #(
      .FWD_STAGES (FWD_STAGES),
      .SEL_W      (SEL_W)
    ) u_match (
      .entries_i  (trk_q),
      .id_valid_i (ID_VALID),
      .rs_i       (ID_RS[g]),
      .rs_used_i  (ID_RS_USED[g]),
      .hit_o      (hit[g]),
      .sel_o      (FWD_SEL[g]),
      .is_load_o  (is_load[g]),
      .index_o    (idx[g])
    );
  end

  always_comb begin
    stall = 1'b0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      if (hit[i] && is_load[i] && (32'(idx[i]) < LOAD_LAT)) begin
        stall = 1'b1;
      end
    end
    // A flushed instruction is discarded, so there is nothing to wait for.
    if (FLUSH) begin
      stall = 1'b0;
    end
  end

  assign STALL = stall;

  always_comb begin
    trk_d = '0;
    for (int k = 1; k < int'(FWD_STAGES); k++) begin
      trk_d[k] = trk_q[k-1];
    end
    if (ID_VALID && !stall && !FLUSH) begin
      trk_d[0].valid = 1'b1;
      trk_d[0].rd    = ID_RD;
      trk_d[0].we    = ID_RF_WE;
      trk_d[0].load  = ID_IS_LOAD;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  assign STALL_CNT = stall_cnt_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      trk_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      trk_q       <= trk_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Scoreboard bench: two configurations (default, and FWD_STAGES=3/LOAD_LAT=2) share stimulus.
module tb_hazard_forward_unit;

  typedef struct {
    logic [1:0]  sel0_a;
    logic [1:0]  sel1_a;
    logic        stall_a;
    logic [15:0] cnt_a;
    logic [1:0]  sel0_b;
    logic [1:0]  sel1_b;
    logic        stall_b;
    logic [15:0] cnt_b;
    string       name;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            id_valid;
  logic [1:0][4:0] id_rs;
  logic [1:0]      id_rs_used;
  logic [4:0]      id_rd;
  logic            id_we;
  logic            id_ld;
  logic            flush;
  logic [1:0][1:0] sel_a, sel_b;
  logic            stall_a, stall_b;
  logic [15:0]     cnt_a, cnt_b;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  hazard_forward_unit u_dut_a (
    .CLK        (clk),
    .RST        (rst),
    .ID_VALID   (id_valid),
    .ID_RS      (id_rs),
    .ID_RS_USED (id_rs_used),
    .ID_RD      (id_rd),
    .ID_RF_WE   (id_we),
    .ID_IS_LOAD (id_ld),
    .FLUSH      (flush),
    .FWD_SEL    (sel_a),
    .STALL      (stall_a),
    .STALL_CNT  (cnt_a)
  );

  hazard_forward_unit #(
    .NUM_SRC    (2),
    .FWD_STAGES (3),
    .LOAD_LAT   (2)
  ) u_dut_b (
    .CLK        (clk),
    .RST        (rst),
    .ID_VALID   (id_valid),
    .ID_RS      (id_rs),
    .ID_RS_USED (id_rs_used),
    .ID_RD      (id_rd),
    .ID_RF_WE   (id_we),
    .ID_IS_LOAD (id_ld),
    .FLUSH      (flush),
    .FWD_SEL    (sel_b),
    .STALL      (stall_b),
    .STALL_CNT  (cnt_b)
  );

  task automatic chk(input string nm, input string fld, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s %s: got %0d expected %0d", nm, fld, act, exp);
    end
  endtask

  // Monitor: every cycle with a pending expectation is compared mid-cycle.
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      chk(mon_e.name, "a.fwd_sel0", int'(sel_a[0]), int'(mon_e.sel0_a));
      chk(mon_e.name, "a.fwd_sel1", int'(sel_a[1]), int'(mon_e.sel1_a));
      chk(mon_e.name, "a.stall",    int'(stall_a),  int'(mon_e.stall_a));
      chk(mon_e.name, "a.stall_cnt", int'(cnt_a),   int'(mon_e.cnt_a));
      chk(mon_e.name, "b.fwd_sel0", int'(sel_b[0]), int'(mon_e.sel0_b));
      chk(mon_e.name, "b.fwd_sel1", int'(sel_b[1]), int'(mon_e.sel1_b));
      chk(mon_e.name, "b.stall",    int'(stall_b),  int'(mon_e.stall_b));
      chk(mon_e.name, "b.stall_cnt", int'(cnt_b),   int'(mon_e.cnt_b));
    end
  end

  task automatic step(
    input logic r, input logic v, input logic [4:0] rs0, input logic [4:0] rs1,
    input logic [1:0] used, input logic [4:0] rd, input logic we, input logic ld,
    input logic fl,
    input logic [1:0] a0, input logic [1:0] a1, input logic as, input int ac,
    input logic [1:0] b0, input logic [1:0] b1, input logic bs, input int bc,
    input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst        = r;
    id_valid   = v;
    id_rs[0]   = rs0;
    id_rs[1]   = rs1;
    id_rs_used = used;
    id_rd      = rd;
    id_we      = we;
    id_ld      = ld;
    flush      = fl;
    e.sel0_a  = a0;
    e.sel1_a  = a1;
    e.stall_a = as;
    e.cnt_a   = 16'(ac);
    e.sel0_b  = b0;
    e.sel1_b  = b1;
    e.stall_b = bs;
    e.cnt_b   = 16'(bc);
    e.name    = nm;
    sb.push_back(e);
  endtask

  initial begin
    rst = 1'b1; id_valid = 1'b0; id_rs = '0; id_rs_used = '0;
    id_rd = '0; id_we = 1'b0; id_ld = 1'b0; flush = 1'b0;
    //   r v rs0 rs1 used  rd we ld fl | a0 a1 as ac | b0 b1 bs bc
    step(1, 0, 0,  0,  2'b00, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "reset");
    step(0, 1, 0,  0,  2'b00, 5,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "add_x5");
    step(0, 1, 5,  0,  2'b01, 6,  1, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, "b2b_alu");
    step(0, 1, 0,  0,  2'b00, 5,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "wr_x5_a");
    step(0, 1, 0,  0,  2'b00, 5,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "wr_x5_b");
    step(0, 1, 5,  0,  2'b01, 9,  0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, "prio_young");
    step(0, 1, 0,  0,  2'b00, 5,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "wr_x5_c");
    step(0, 1, 0,  0,  2'b00, 8,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "wr_x8");
    step(0, 1, 5,  8,  2'b11, 0,  0, 0, 0, 2, 1, 0, 0, 2, 1, 0, 0, "prio_gap");
    step(0, 1, 0,  0,  2'b00, 7,  1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "lw_x7");
    step(0, 1, 7,  0,  2'b01, 10, 1, 0, 0, 1, 0, 1, 0, 1, 0, 1, 0, "lu_stall");
    step(0, 1, 7,  0,  2'b01, 10, 1, 0, 0, 2, 0, 0, 1, 2, 0, 1, 1, "lu_fwd_a");
    step(0, 1, 7,  0,  2'b01, 10, 1, 0, 0, 0, 0, 0, 1, 3, 0, 0, 2, "lu_fwd_b");
    step(0, 1, 0,  0,  2'b00, 0,  1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 2, "lw_x0");
    step(0, 1, 0,  10, 2'b01, 0,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2, "x0_unused");
    step(0, 1, 0,  0,  2'b00, 7,  1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 2, "lw_x7_2");
    step(0, 1, 7,  0,  2'b01, 11, 1, 0, 1, 1, 0, 0, 1, 1, 0, 0, 2, "flush_lu");
    step(0, 1, 11, 7,  2'b11, 0,  0, 0, 0, 0, 2, 0, 1, 0, 2, 1, 2, "flush_bubble");
    step(0, 1, 0,  0,  2'b00, 12, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 3, "wr_x12");
    step(0, 1, 0,  0,  2'b00, 12, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 3, "lw_x12");
    step(0, 1, 12, 0,  2'b01, 0,  0, 0, 0, 1, 0, 1, 1, 1, 0, 1, 3, "ld_over_alu");
    step(0, 1, 12, 0,  2'b01, 0,  0, 0, 0, 2, 0, 0, 2, 2, 0, 1, 4, "ld_over_alu_fwd");
    step(0, 1, 0,  0,  2'b00, 13, 1, 1, 0, 0, 0, 0, 2, 0, 0, 0, 5, "lw_x13");
    step(0, 1, 13, 0,  2'b01, 0,  0, 0, 0, 1, 0, 1, 2, 1, 0, 1, 5, "pre_rst_stall");
    step(1, 1, 13, 0,  2'b01, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "rst_mid_stall");
    step(0, 1, 13, 0,  2'b01, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "post_rst");
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
